// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - NEC IR symbol timing windows (us) and decoder state enum
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REPEAT_MARK
  } state_t;

  localparam int unsigned DUR_W = 14;

  // Nominal symbol lengths are 9000/4500/2250/562/562/1687 us; windows are -25%/+25%
  localparam int unsigned LEAD_MARK_MIN  = 6750;
  localparam int unsigned LEAD_MARK_MAX  = 11250;
  localparam int unsigned LEAD_SPACE_MIN = 3375;
  localparam int unsigned LEAD_SPACE_MAX = 5625;
  localparam int unsigned RPT_SPACE_MIN  = 1688;
  localparam int unsigned RPT_SPACE_MAX  = 2812;
  localparam int unsigned BIT_MARK_MIN   = 422;
  localparam int unsigned BIT_MARK_MAX   = 703;
  localparam int unsigned ZERO_SPACE_MIN = 422;
  localparam int unsigned ZERO_SPACE_MAX = 703;
  localparam int unsigned ONE_SPACE_MIN  = 1266;
  localparam int unsigned ONE_SPACE_MAX  = 2109;

  function automatic logic in_win(input logic [DUR_W-1:0] d, input int unsigned lo,
                                  input int unsigned hi);
    return (32'(d) >= lo) && (32'(d) <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_decoder_if.sv
// rtl/nec_ir_decoder_if.sv - IR line in, decoded code and status pulses out
interface nec_ir_decoder_if;
  logic        ir_in;
  logic [31:0] decoded_ir_out;
  logic        decoded_ir_out_valid;
  logic        error_out;

  modport master (
    input  ir_in,
    output decoded_ir_out,
    output decoded_ir_out_valid,
    output error_out
  );

  modport slave (
    output ir_in,
    input  decoded_ir_out,
    input  decoded_ir_out_valid,
    input  error_out
  );
endinterface

// File: rtl/ir_pulse_timer.sv
// rtl/ir_pulse_timer.sv - 1 us tick prescaler and saturating 14-bit duration counter
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 74_250_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [DUR_W-1:0] duration
);
  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(DIV - 1));

  // Every line edge restarts both the prescaler and the measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      duration <= '0;
    end else if (clear) begin
      pre_q    <= '0;
      duration <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick && (duration != {DUR_W{1'b1}})) duration <= duration + 1'b1;
    end
  end
endmodule

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - single metastability stage, resets to the idle-high line level
module synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  // One flop stage; chain two instances for a full synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b1;
    else        q <= d;
  end
endmodule

// File: rtl/nec_ir_decoder.sv
// rtl/nec_ir_decoder.sv - NEC IR frame decoder; define NEC_IR_REPEAT_EN to re-pulse valid on repeat frames
module nec_ir_decoder
  import ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 74_250_000,
  parameter int unsigned TIMEOUT_US  = 12000
) (
  input  logic                    clk_pixel_in,
  input  logic                    rst_in,
  nec_ir_decoder_if.master        ir_bus
);
  logic             ir_meta, ir_sync, ir_prev;
  logic             fall, rise;
  logic [DUR_W-1:0] duration;
  logic             timeout;
  state_t           state_q, state_d;
  logic             reject, accept, rpt, shift_en, shift_bit, valid_d, err_d;
  logic [31:0]      shreg, decoded_q;
  logic [4:0]       bit_cnt;
  logic             valid_q, err_q;

  synchronizer u_sync0 (.clk(clk_pixel_in), .rst_n(rst_in), .d(ir_bus.ir_in), .q(ir_meta));
  synchronizer u_sync1 (.clk(clk_pixel_in), .rst_n(rst_in), .d(ir_meta),      .q(ir_sync));

  ir_pulse_timer #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_timer (
    .clk      (clk_pixel_in),
    .rst_n    (rst_in),
    .clear    (fall | rise),
    .duration (duration)
  );

  assign timeout = (32'(duration) >= TIMEOUT_US);

  // Registered edge pulses; an edge can only follow its opposite, so after a
  // reject with the line low a new leader needs a rising edge first
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      ir_prev <= 1'b1;
      fall    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      ir_prev <= ir_sync;
      fall    <= ir_prev & ~ir_sync;
      rise    <= ~ir_prev & ir_sync;
    end
  end

  // State register
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state from the current symbol's verdict
  always_comb begin
    state_d = state_q;
    if (reject) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:        if (fall) state_d = LEAD_MARK;
        LEAD_MARK:   if (rise) state_d = LEAD_SPACE;
        LEAD_SPACE:  if (fall) state_d = in_win(duration, LEAD_SPACE_MIN, LEAD_SPACE_MAX)
                                         ? BIT_MARK : REPEAT_MARK;
        BIT_MARK:    if (rise) state_d = BIT_SPACE;
        BIT_SPACE:   if (fall) state_d = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
        STOP_MARK,
        REPEAT_MARK: if (rise) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Symbol classification and pulse requests; a timeout wins over any edge
  always_comb begin
    reject    = 1'b0;
    accept    = 1'b0;
    rpt       = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    if ((state_q != IDLE) && timeout) begin
      reject = 1'b1;
    end else begin
      case (state_q)
        LEAD_MARK:   if (rise && !in_win(duration, LEAD_MARK_MIN, LEAD_MARK_MAX)) reject = 1'b1;
        LEAD_SPACE:  if (fall && !in_win(duration, LEAD_SPACE_MIN, LEAD_SPACE_MAX)
                              && !in_win(duration, RPT_SPACE_MIN, RPT_SPACE_MAX)) reject = 1'b1;
        BIT_MARK:    if (rise && !in_win(duration, BIT_MARK_MIN, BIT_MARK_MAX)) reject = 1'b1;
        BIT_SPACE: begin
          if (fall) begin
            if (in_win(duration, ZERO_SPACE_MIN, ZERO_SPACE_MAX)) begin
              shift_en = 1'b1;
            end else if (in_win(duration, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
              shift_en  = 1'b1;
              shift_bit = 1'b1;
            end else begin
              reject = 1'b1;
            end
          end
        end
        STOP_MARK: begin
          if (rise) begin
            if (shreg[15:8] == ~shreg[7:0]) accept = 1'b1;
            else                            reject = 1'b1;
          end
        end
        REPEAT_MARK: if (rise) rpt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef NEC_IR_REPEAT_EN
  logic have_code;

  // Repeats are only meaningful once a full code has been accepted
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in)     have_code <= 1'b0;
    else if (accept) have_code <= 1'b1;
  end

  assign valid_d = accept | (rpt & have_code);
  assign err_d   = reject | (rpt & ~have_code);
`else
  assign valid_d = accept;
  assign err_d   = reject;
`endif

  // Shift register, bit counter, held output code and the one-cycle pulses
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      decoded_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      if ((state_q == LEAD_SPACE) && (state_d == BIT_MARK)) bit_cnt <= '0;
      else if (shift_en)                                    bit_cnt <= bit_cnt + 5'd1;
      if (shift_en) shreg     <= {shreg[30:0], shift_bit};
      if (accept)   decoded_q <= shreg;
    end
  end

  assign ir_bus.decoded_ir_out       = decoded_q;
  assign ir_bus.decoded_ir_out_valid = valid_q;
  assign ir_bus.error_out            = err_q;
endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb/tb_nec_ir_decoder.sv - directed vector bench for nec_ir_decoder at 1 MHz (one tick per cycle)
module tb_nec_ir_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0, n_err = 0, n_both = 0;
  int   v0, e0, lat;

`ifdef NEC_IR_REPEAT_EN
  localparam int RPT_NOCODE_ERR = 1;
  localparam int RPT_PULSE      = 1;
`else
  localparam int RPT_NOCODE_ERR = 0;
  localparam int RPT_PULSE      = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] code;
    int          pct;
    int          lead_us;
    bit          lead_only;
    int          exp_valid;
    int          exp_err;
    logic [31:0] exp_code;
  } vec_t;

  vec_t vecs[5];

  nec_ir_decoder_if bus ();

  nec_ir_decoder #(.CLK_FREQ_HZ(1_000_000), .TIMEOUT_US(12000)) dut (
    .clk_pixel_in (clk),
    .rst_in       (rst_n),
    .ir_bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.decoded_ir_out_valid) n_valid++;
    if (bus.error_out) n_err++;
    if (bus.decoded_ir_out_valid && bus.error_out) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic level, input int us);
    bus.ir_in = level;
    repeat (us) @(negedge clk);
  endtask

  function automatic int sc(input int us, input int pct);
    return us * pct / 100;
  endfunction

  // Leader, 32 bits and the stop mark, leaving the line low at the end
  task automatic send_body(input logic [31:0] code, input int pct, input int lead_us);
    hold(1'b0, lead_us);
    hold(1'b1, sc(4500, pct));
    for (int i = 31; i >= 0; i--) begin
      hold(1'b0, sc(562, pct));
      hold(1'b1, code[i] ? sc(1687, pct) : sc(562, pct));
    end
    hold(1'b0, sc(562, pct));
  endtask

  task automatic send_frame(input logic [31:0] code, input int pct, input int lead_us,
                            input bit lead_only);
    if (lead_only) begin
      hold(1'b0, lead_us);
      hold(1'b1, 200);
    end else begin
      send_body(code, pct, lead_us);
      hold(1'b1, 200);
    end
  endtask

  task automatic send_repeat();
    hold(1'b0, 9000);
    hold(1'b1, 2250);
    hold(1'b0, 562);
    hold(1'b1, 200);
  endtask

  initial begin
    vecs[0] = '{"nominal_906f", 32'h20DF906F, 100, 9000,  1'b0, 1, 0, 32'h20DF906F};
    vecs[1] = '{"plus20_41be",  32'h20DF41BE, 120, 10800, 1'b0, 1, 0, 32'h20DF41BE};
    vecs[2] = '{"lead_12000",   32'h20DF41BE, 100, 12000, 1'b1, 0, 1, 32'h20DF41BE};
    vecs[3] = '{"bad_cmd_906e", 32'h20DF906E, 100, 9000,  1'b0, 0, 1, 32'h20DF41BE};
    vecs[4] = '{"lead_6000",    32'h20DF41BE, 100, 6000,  1'b1, 0, 1, 32'h20DF41BE};

    bus.ir_in = 1'b1;
    rst_n     = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_code",  bus.decoded_ir_out, 32'h0);
    check("reset_valid", 32'(bus.decoded_ir_out_valid), 32'd0);
    check("reset_error", 32'(bus.error_out), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    v0 = n_valid; e0 = n_err;
    send_repeat();
    check("repeat_nocode_valid", 32'(n_valid - v0), 32'd0);
    check("repeat_nocode_error", 32'(n_err - e0), 32'(RPT_NOCODE_ERR));

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[i].code, vecs[i].pct, vecs[i].lead_us, vecs[i].lead_only);
      check({vecs[i].name, "_valid"}, 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check({vecs[i].name, "_error"}, 32'(n_err - e0), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_code"},  bus.decoded_ir_out, vecs[i].exp_code);
    end

    // Line stuck low mid-frame: the error must come while the line is still low
    v0 = n_valid; e0 = n_err;
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 562);
      hold(1'b1, 562);
    end
    hold(1'b0, 13000);
    check("timeout_error_while_low", 32'(n_err - e0), 32'd1);
    check("timeout_valid",           32'(n_valid - v0), 32'd0);
    hold(1'b1, 200);
    check("timeout_code_held",       bus.decoded_ir_out, 32'h20DF41BE);
    check("timeout_no_late_error",   32'(n_err - e0), 32'd1);

    v0 = n_valid; e0 = n_err;
    send_frame(32'h20DFC13E, 100, 9000, 1'b0);
    check("c13e_valid", 32'(n_valid - v0), 32'd1);
    check("c13e_error", 32'(n_err - e0), 32'd0);
    check("c13e_code",  bus.decoded_ir_out, 32'h20DFC13E);

    v0 = n_valid; e0 = n_err;
    send_repeat();
    send_repeat();
    check("repeat_valid", 32'(n_valid - v0), 32'(2 * RPT_PULSE));
    check("repeat_error", 32'(n_err - e0), 32'd0);
    check("repeat_code",  bus.decoded_ir_out, 32'h20DFC13E);

    // Reset in the mark of bit 17
    v0 = n_valid; e0 = n_err;
    hold(1'b0, 9000);
    hold(1'b1, 4500);
    for (int i = 31; i >= 15; i--) begin
      hold(1'b0, 562);
      hold(1'b1, vecs[0].code[i] ? 1687 : 562);
    end
    hold(1'b0, 200);
    rst_n = 1'b0;
    #1;
    check("midreset_code",  bus.decoded_ir_out, 32'h0);
    check("midreset_valid", 32'(bus.decoded_ir_out_valid), 32'd0);
    check("midreset_error", 32'(bus.error_out), 32'd0);
    @(negedge clk);
    bus.ir_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midreset_no_valid", 32'(n_valid - v0), 32'd0);
    check("midreset_no_error", 32'(n_err - e0), 32'd0);

    // Full frame after reset, timing the final rising edge to the valid pulse
    v0 = n_valid; e0 = n_err;
    send_body(32'h20DF5BA4, 100, 9000);
    bus.ir_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.decoded_ir_out_valid && (lat == 0)) lat = k;
    end
    check("latency_cycles", 32'(lat), 32'd4);
    repeat (50) @(negedge clk);
    check("5ba4_valid", 32'(n_valid - v0), 32'd1);
    check("5ba4_error", 32'(n_err - e0), 32'd0);
    check("5ba4_code",  bus.decoded_ir_out, 32'h20DF5BA4);

    check("valid_error_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nec_ir_decoder.md
NEC_IR_DECODER -- requirements
Module: nec_ir_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 74_250_000, clk_pixel_in frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 12000, maximum mark/space length in microseconds before frame abort.
REQ-003 SHALL have port clk_pixel_in  input  1  pixel clock, sole clock.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ir_in  input  1  raw IR receiver output, asynchronous, low = carrier present (mark).
REQ-006 SHALL have port decoded_ir_out  output  32  last accepted NEC code, first-received bit in bit 31.
REQ-007 SHALL have port decoded_ir_out_valid  output  1  one-cycle pulse per accepted frame.
REQ-008 SHALL have port error_out  output  1  one-cycle pulse per rejected frame.

Function
REQ-009 SHALL pass ir_in through a 2-FF synchronizer, then a registered edge detector; all timing is measured on the synchronized signal.
REQ-010 SHALL derive a 1 us tick from a prescaler of CLK_FREQ_HZ/1_000_000 cycles (integer truncation); a 14-bit duration counter increments per tick, clears on every synchronized edge, and saturates at 16383.
REQ-011 SHALL implement FSM states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK.
REQ-012 IDLE -> LEAD_MARK on falling edge; the prescaler restarts on that edge.
REQ-013 LEAD_MARK -> LEAD_SPACE on rising edge when duration is 6750..11250 us, else reject.
REQ-014 LEAD_SPACE on falling edge: 3375..5625 us -> BIT_MARK with bit count 0; 1688..2812 us -> REPEAT_MARK; else reject.
REQ-015 BIT_MARK -> BIT_SPACE on rising edge when duration is 422..703 us, else reject.
REQ-016 BIT_SPACE on falling edge: 422..703 us shifts in 0, 1266..2109 us shifts in 1, else reject; shift is MSB-first (shreg <= {shreg[30:0], bit}).
REQ-017 After the 32nd bit the FSM goes to STOP_MARK; otherwise it returns to BIT_MARK.
REQ-018 STOP_MARK on rising edge: if shreg[15:8] == ~shreg[7:0], decoded_ir_out <= shreg and decoded_ir_out_valid pulses, else reject; then IDLE.
REQ-019 REPEAT_MARK on rising edge: handled per REQ-026/027; then IDLE.
REQ-020 In any non-IDLE state, duration reaching TIMEOUT_US SHALL reject immediately, without waiting for an edge.
REQ-021 Reject SHALL mean: error_out pulses for one cycle, FSM -> IDLE, decoded_ir_out unchanged. If the line is low at that point, IDLE SHALL wait for a rising edge before accepting a new falling edge.
REQ-022 decoded_ir_out SHALL hold its value between frames (consumers compare it at level); valid and error SHALL never assert in the same cycle.
REQ-023 Latency from the ir_in edge that ends a frame to the valid/error pulse SHALL be a fixed 4 clk_pixel_in cycles.

Reset
REQ-024 Asserting rst_in at any time, including mid-frame, SHALL asynchronously force: FSM IDLE, decoded_ir_out 32'h0, valid 0, error 0, counters 0, synchronizer FFs 1, have_code 0.
REQ-025 A frame interrupted by reset SHALL produce no pulse; decoding resumes on the first falling edge after reset deassertion.

Configuration
REQ-026 With macro NEC_IR_REPEAT_EN defined, an accepted repeat frame SHALL re-pulse decoded_ir_out_valid with decoded_ir_out unchanged, but only if have_code is 1 (set by the first accepted full frame); with have_code 0 it SHALL pulse error_out.
REQ-027 Without NEC_IR_REPEAT_EN, repeat frames SHALL be consumed silently (no valid, no error).

Structure
REQ-028 SHALL place the timing window constants (us min/max per symbol) and the FSM state enum in shared package ir_pkg.
REQ-029 SHALL instantiate the existing synchronizer module twice, serially, for REQ-009; the tick/duration counter SHALL be sub-module ir_pulse_timer.

Verification
REQ-030 Full NEC frame 32'h20DF906F at nominal timing -> one valid pulse, decoded_ir_out = 32'h20DF906F, no error.
REQ-031 Frame 32'h20DF41BE with all timings +20% -> accepted; same frame with leader mark 12000 us -> error pulse, output unchanged.
REQ-032 Frame 32'h20DF906E (command check fails) -> error pulse, decoded_ir_out keeps the previous value.
REQ-033 With NEC_IR_REPEAT_EN: frame 32'h20DFC13E then two repeat frames -> three valid pulses, all showing 32'h20DFC13E; repeat right after reset -> error. Without NEC_IR_REPEAT_EN: only one pulse and no error.
REQ-034 Line held low 13 ms mid-frame -> error at TIMEOUT_US and no valid; then a nominal frame -> accepted.
REQ-035 rst_in asserted after bit 16 -> outputs zero immediately; next full frame 32'h20DF5BA4 -> accepted.
